// File: rtl/mig_app_responder_if.sv
// MIG user (app) interface bundle: command, write-data and read-return channels
// plus calibration/status. master = bridge side, slave = memory side.
interface mig_app_responder_if;
  logic [26:0] app_addr;
  logic [2:0]  app_cmd;
  logic        app_en;
  logic        app_rdy;
  logic [63:0] app_wdf_data;
  logic [7:0]  app_wdf_mask;
  logic        app_wdf_wren;
  logic        app_wdf_end;
  logic        app_wdf_rdy;
  logic [63:0] app_rd_data;
  logic        app_rd_data_valid;
  logic        app_rd_data_end;
  logic        init_calib_complete;
  logic        protocol_err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  init_calib_complete, protocol_err
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output init_calib_complete, protocol_err
  );
endinterface

// File: rtl/mig_app_responder.sv
// Deterministic stand-in for the MIG core: queues commands and write beats, stores
// 64-bit beats in an internal array and returns two-beat read bursts at fixed latency.
module mig_app_responder #(
  parameter int MEM_AW       = 10,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int READ_LATENCY = 8,
  parameter int CALIB_CYCLES = 16,
  parameter int STALL_PERIOD = 0
) (
  input logic                ui_clk,
  input logic                ui_clk_sync_rst,
  mig_app_responder_if.slave app
);

  localparam int MEM_DEPTH  = 1 << MEM_AW;
  localparam int BURST_W    = MEM_AW - 1;
  localparam int CMD_PW     = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CMD_CW     = $clog2(CMD_DEPTH + 1);
  localparam int WDF_PW     = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
  localparam int WDF_CW     = $clog2(WDF_DEPTH + 1);
  localparam int CAL_W      = $clog2(CALIB_CYCLES + 1);
  localparam int STALL_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int STALL_LAST = (STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0;
  localparam int WAIT_W     = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam int WAIT_LOAD  = (READ_LATENCY > 3) ? READ_LATENCY - 3 : 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR0, ST_WR1, ST_RD_WAIT, ST_RD0, ST_RD1
  } state_t;

  typedef struct packed {
    logic [2:0]         cmd;
    logic [BURST_W-1:0] burst;
  } cmd_entry_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        last_beat;
  } wdf_entry_t;

  // ---------------- calibration and stall generation ----------------
  logic [CAL_W-1:0]   calib_cnt_reg;
  logic               calib_reg;
  logic [STALL_W-1:0] stall_cnt_reg;
  logic               stall;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      calib_cnt_reg <= '0;
      calib_reg     <= 1'b0;
    end else if (!calib_reg) begin
      calib_cnt_reg <= calib_cnt_reg + 1'b1;
      if (calib_cnt_reg == CAL_W'(CALIB_CYCLES - 1)) calib_reg <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst || stall_cnt_reg == STALL_W'(STALL_LAST)) stall_cnt_reg <= '0;
    else                                                          stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign stall = (STALL_PERIOD != 0) && (stall_cnt_reg == STALL_W'(STALL_LAST));

  // ---------------- command queue ----------------
  cmd_entry_t        cmd_q [CMD_DEPTH];
  logic [CMD_PW-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg;
  logic [CMD_CW-1:0] cmd_cnt_reg;
  logic              cmd_push, cmd_pop;
  cmd_entry_t        cmd_head;

  // Ready is a function of registered state only, never of app_en.
  assign app.app_rdy = calib_reg && (cmd_cnt_reg < CMD_CW'(CMD_DEPTH)) && !stall;
  assign cmd_push    = app.app_en && app.app_rdy;
  assign cmd_head    = cmd_q[cmd_rd_ptr_reg];

  always_ff @(posedge ui_clk) begin
    if (cmd_push) cmd_q[cmd_wr_ptr_reg] <= '{cmd: app.app_cmd, burst: app.app_addr[MEM_AW+1:3]};
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      cmd_wr_ptr_reg <= '0;
      cmd_rd_ptr_reg <= '0;
      cmd_cnt_reg    <= '0;
    end else begin
      if (cmd_push)
        cmd_wr_ptr_reg <= (cmd_wr_ptr_reg == CMD_PW'(CMD_DEPTH - 1)) ? '0 : cmd_wr_ptr_reg + 1'b1;
      if (cmd_pop)
        cmd_rd_ptr_reg <= (cmd_rd_ptr_reg == CMD_PW'(CMD_DEPTH - 1)) ? '0 : cmd_rd_ptr_reg + 1'b1;
      cmd_cnt_reg <= cmd_cnt_reg + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
    end
  end

  // ---------------- write-data queue ----------------
  wdf_entry_t        wdf_q [WDF_DEPTH];
  logic [WDF_PW-1:0] wdf_wr_ptr_reg, wdf_rd_ptr_reg;
  logic [WDF_CW-1:0] wdf_cnt_reg;
  logic              wdf_push, wdf_pop;
  wdf_entry_t        wdf_head;

  assign app.app_wdf_rdy = calib_reg && (wdf_cnt_reg < WDF_CW'(WDF_DEPTH));
  assign wdf_push        = app.app_wdf_wren && app.app_wdf_rdy;
  assign wdf_head        = wdf_q[wdf_rd_ptr_reg];

  always_ff @(posedge ui_clk) begin
    if (wdf_push)
      wdf_q[wdf_wr_ptr_reg] <= '{data: app.app_wdf_data, mask: app.app_wdf_mask,
                                 last_beat: app.app_wdf_end};
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      wdf_wr_ptr_reg <= '0;
      wdf_rd_ptr_reg <= '0;
      wdf_cnt_reg    <= '0;
    end else begin
      if (wdf_push)
        wdf_wr_ptr_reg <= (wdf_wr_ptr_reg == WDF_PW'(WDF_DEPTH - 1)) ? '0 : wdf_wr_ptr_reg + 1'b1;
      if (wdf_pop)
        wdf_rd_ptr_reg <= (wdf_rd_ptr_reg == WDF_PW'(WDF_DEPTH - 1)) ? '0 : wdf_rd_ptr_reg + 1'b1;
      wdf_cnt_reg <= wdf_cnt_reg + WDF_CW'(wdf_push) - WDF_CW'(wdf_pop);
    end
  end

  // ---------------- executor FSM ----------------
  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [BURST_W-1:0] cur_burst_reg;
  logic               mem_we, mem_beat, rd_en, rd_beat, err_set;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      cur_burst_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (cmd_pop) cur_burst_reg <= cmd_head.burst;
    end
  end

  // RD_WAIT spans READ_LATENCY-2 cycles so the registered beat lands at T+READ_LATENCY.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_cnt_reg != '0) begin
          if (cmd_head.cmd == 3'd0) begin
            state_next = ST_WR0;
          end else if (cmd_head.cmd == 3'd1) begin
            state_next    = (READ_LATENCY > 2) ? ST_RD_WAIT : ST_RD0;
            wait_cnt_next = WAIT_W'(WAIT_LOAD);
          end
        end
      end
      ST_WR0:     if (wdf_cnt_reg != '0) state_next = ST_WR1;
      ST_WR1:     if (wdf_cnt_reg != '0) state_next = ST_IDLE;
      ST_RD_WAIT: begin
        if (wait_cnt_reg == '0) state_next = ST_RD0;
        else                    wait_cnt_next = wait_cnt_reg - 1'b1;
      end
      ST_RD0:     state_next = ST_RD1;
      ST_RD1:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_pop  = 1'b0;
    wdf_pop  = 1'b0;
    mem_we   = 1'b0;
    mem_beat = 1'b0;
    rd_en    = 1'b0;
    rd_beat  = 1'b0;
    err_set  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_cnt_reg != '0) begin
          cmd_pop = 1'b1;
          err_set = (cmd_head.cmd > 3'd1);
        end
      end
      ST_WR0: begin
        if (wdf_cnt_reg != '0) begin
          wdf_pop = 1'b1;
          mem_we  = 1'b1;
          err_set = wdf_head.last_beat;
        end
      end
      ST_WR1: begin
        if (wdf_cnt_reg != '0) begin
          wdf_pop  = 1'b1;
          mem_we   = 1'b1;
          mem_beat = 1'b1;
          err_set  = !wdf_head.last_beat;
        end
      end
      ST_RD0: rd_en = 1'b1;
      ST_RD1: begin
        rd_en   = 1'b1;
        rd_beat = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- beat store ----------------
  logic [63:0]       mem [MEM_DEPTH] = '{default: '0};
  logic [7:0]        byte_we;
  logic [MEM_AW-1:0] mem_waddr, mem_raddr;

  assign mem_waddr = {cur_burst_reg, mem_beat};
  assign mem_raddr = {cur_burst_reg, rd_beat};

  // Mask bit set means the byte is left untouched; nothing is written while in reset.
  for (genvar gi = 0; gi < 8; gi++) begin : g_byte_we
    assign byte_we[gi] = mem_we && !wdf_head.mask[gi] && !ui_clk_sync_rst;
  end

  always_ff @(posedge ui_clk) begin
    for (int b = 0; b < 8; b++) begin
      if (byte_we[b]) mem[mem_waddr][b*8 +: 8] <= wdf_head.data[b*8 +: 8];
    end
  end

  // ---------------- read return and status ----------------
  logic [63:0] rd_data_reg;
  logic        rd_valid_reg, rd_end_reg, protocol_err_reg;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      rd_data_reg      <= '0;
      rd_valid_reg     <= 1'b0;
      rd_end_reg       <= 1'b0;
      protocol_err_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      rd_end_reg   <= rd_en && rd_beat;
      if (rd_en)   rd_data_reg      <= mem[mem_raddr];
      if (err_set) protocol_err_reg <= 1'b1;
    end
  end

  assign app.app_rd_data         = rd_data_reg;
  assign app.app_rd_data_valid   = rd_valid_reg;
  assign app.app_rd_data_end     = rd_end_reg;
  assign app.init_calib_complete = calib_reg;
  assign app.protocol_err        = protocol_err_reg;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, app.app_addr[2:0], app.app_addr[26:MEM_AW+2]};

endmodule

// File: tb/tb_mig_app_responder.sv
// Scoreboard bench for mig_app_responder: expected read beats are queued when a read
// is accepted and compared as beats come back; a second instance runs with stalls.
module tb_mig_app_responder;
  localparam int READ_LAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mig_app_responder_if bus ();
  mig_app_responder_if bus_st ();

  mig_app_responder dut (.ui_clk(clk), .ui_clk_sync_rst(rst), .app(bus));
  mig_app_responder #(.STALL_PERIOD(3)) dut_st (.ui_clk(clk), .ui_clk_sync_rst(rst), .app(bus_st));

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          min_cyc;
    int          exact_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_mem [1024];
  int          total = 0;
  int          bad = 0;
  int          beats = 0;
  logic [26:0] burst_addrs [6] = '{27'h10, 27'h40, 27'h18, 27'h10, 27'h40, 27'h48};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ent(input logic [26:0] a, input int b);
    return (int'(a[11:3]) << 1) | (b & 1);
  endfunction

  task automatic model_write(input int e, input logic [63:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++)
      if (!m[b]) model_mem[e][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic push_read_exp(input logic [26:0] a, input int acc, input bit exact);
    exp_t e;
    for (int b = 0; b < 2; b++) begin
      e.data      = model_mem[ent(a, b)];
      e.last      = (b == 1);
      e.min_cyc   = acc + READ_LAT + b;
      e.exact_cyc = exact ? acc + READ_LAT + b : 0;
      sb.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [26:0] a, output int acc);
    logic r;
    bus.app_cmd  = c;
    bus.app_addr = a;
    bus.app_en   = 1'b1;
    acc = -1;
    for (int n = 0; n < 200; n++) begin
      r = bus.app_rdy;
      step();
      if (r) begin
        acc = cyc;
        break;
      end
    end
    bus.app_en = 1'b0;
    if (acc < 0) check("cmd_timeout", 0, 1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] m, input logic l);
    logic r;
    bit   ok = 0;
    bus.app_wdf_data = d;
    bus.app_wdf_mask = m;
    bus.app_wdf_end  = l;
    bus.app_wdf_wren = 1'b1;
    for (int n = 0; n < 200; n++) begin
      r = bus.app_wdf_rdy;
      step();
      if (r) begin
        ok = 1;
        break;
      end
    end
    bus.app_wdf_wren = 1'b0;
    if (!ok) check("beat_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [26:0] a, input logic [63:0] d0, input logic [7:0] m0,
                          input logic [63:0] d1, input logic [7:0] m1, input bit beats_first);
    int acc;
    if (beats_first) begin
      send_beat(d0, m0, 1'b0);
      send_beat(d1, m1, 1'b1);
      repeat (4) step();
      send_cmd(3'd0, a, acc);
    end else begin
      send_cmd(3'd0, a, acc);
      send_beat(d0, m0, 1'b0);
      send_beat(d1, m1, 1'b1);
    end
    model_write(ent(a, 0), d0, m0);
    model_write(ent(a, 1), d1, m1);
  endtask

  task automatic do_read(input logic [26:0] a, input bit exact);
    int acc;
    send_cmd(3'd1, a, acc);
    if (acc >= 0) push_read_exp(a, acc, exact);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) step();
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    repeat (2) step();
  endtask

  // Stall-instance helpers: return the number of not-ready cycles waited.
  task automatic st_cmd(input logic [2:0] c, input logic [26:0] a, output int waited);
    logic r;
    bit   ok = 0;
    bus_st.app_cmd  = c;
    bus_st.app_addr = a;
    bus_st.app_en   = 1'b1;
    waited = 0;
    for (int n = 0; n < 200; n++) begin
      r = bus_st.app_rdy;
      step();
      if (r) begin
        ok = 1;
        break;
      end
      waited++;
    end
    bus_st.app_en = 1'b0;
    if (!ok) check("st_cmd_timeout", 0, 1);
  endtask

  task automatic st_beat(input logic [63:0] d, input logic l);
    bus_st.app_wdf_data = d;
    bus_st.app_wdf_mask = 8'h00;
    bus_st.app_wdf_end  = l;
    bus_st.app_wdf_wren = 1'b1;
    for (int n = 0; n < 200 && !bus_st.app_wdf_rdy; n++) step();
    step();
    bus_st.app_wdf_wren = 1'b0;
  endtask

  // Read-return monitor for the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus.app_rd_data_valid === 1'b1) begin
      beats++;
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rd_data", bus.app_rd_data, e.data);
        check("rd_end", bus.app_rd_data_end, e.last);
        check("rd_lat_min", cyc >= e.min_cyc, 1);
        if (e.exact_cyc > 0) check("rd_lat_exact", cyc, e.exact_cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, waited, idx, nacc_at_low, b0, lows;
    logic        r, ok;
    logic [8:0]  v;

    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    bus.app_addr = '0;    bus.app_cmd = '0;     bus.app_en = 1'b0;
    bus.app_wdf_data = '0; bus.app_wdf_mask = '0; bus.app_wdf_wren = 1'b0; bus.app_wdf_end = 1'b0;
    bus_st.app_addr = '0;  bus_st.app_cmd = '0;  bus_st.app_en = 1'b0;
    bus_st.app_wdf_data = '0; bus_st.app_wdf_mask = '0; bus_st.app_wdf_wren = 1'b0;
    bus_st.app_wdf_end = 1'b0;

    // Reset values and calibration timing.
    rst = 1'b1;
    repeat (3) step();
    check("rst_app_rdy", bus.app_rdy, 0);
    check("rst_wdf_rdy", bus.app_wdf_rdy, 0);
    check("rst_rd_data", bus.app_rd_data, 0);
    check("rst_rd_valid", bus.app_rd_data_valid, 0);
    check("rst_rd_end", bus.app_rd_data_end, 0);
    check("rst_calib", bus.init_calib_complete, 0);
    check("rst_perr", bus.protocol_err, 0);
    rst = 1'b0;
    repeat (15) step();
    check("calib_early", bus.init_calib_complete, 0);
    check("rdy_early", bus.app_rdy, 0);
    check("wdf_rdy_early", bus.app_wdf_rdy, 0);
    step();
    check("calib_done", bus.init_calib_complete, 1);
    check("rdy_at_calib", bus.app_rdy, 1);
    check("wdf_rdy_at_calib", bus.app_wdf_rdy, 1);
    check("st_calib_done", bus_st.init_calib_complete, 1);

    // Masked write then read with exact latency.
    do_write(27'h10, 64'h0000_0000_DEAD_BEEF, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    repeat (6) step();
    do_read(27'h10, 1);
    drain();

    // Beats delivered ahead of their command.
    do_write(27'h40, 64'h1111_1111_1111_1111, 8'h00, 64'h2222_2222_2222_2222, 8'h00, 1);
    do_read(27'h40, 0);
    drain();
    check("perr_clean", bus.protocol_err, 0);
    repeat (3) step();
    check("rd_data_hold", bus.app_rd_data, 64'h2222_2222_2222_2222);

    // Six reads with app_en held: one is popped at once, so the fifth fills the queue.
    bus.app_cmd  = 3'd1;
    bus.app_addr = burst_addrs[0];
    bus.app_en   = 1'b1;
    idx = 0;
    nacc_at_low = -1;
    b0 = beats;
    for (int n = 0; n < 400 && idx < 6; n++) begin
      r = bus.app_rdy;
      if (!r && nacc_at_low < 0) nacc_at_low = idx;
      step();
      if (r) begin
        push_read_exp(burst_addrs[idx], cyc, 0);
        idx++;
        if (idx < 6) bus.app_addr = burst_addrs[idx];
      end
    end
    bus.app_en = 1'b0;
    check("burst_cmds", idx, 6);
    check("rdy_low_after", nacc_at_low, 5);
    drain();
    check("burst_beats", beats - b0, 12);

    // Stall instance: one low cycle in every three, write held across a stall.
    for (int i = 0; i < 9; i++) begin
      v[i] = bus_st.app_rdy;
      step();
    end
    lows = 9 - $countones(v);
    check("stall_lows", lows, 3);
    check("stall_periodic", v[5:0] == v[8:3], 1);
    for (int n = 0; n < 5 && bus_st.app_rdy; n++) step();
    st_cmd(3'd0, 27'h80, waited);
    check("stall_wait", waited, 1);
    st_beat(64'hA5A5_0000_0000_A5A5, 1'b0);
    st_beat(64'h5A5A_FFFF_FFFF_5A5A, 1'b1);
    repeat (4) step();
    st_cmd(3'd1, 27'h80, waited);
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus_st.app_rd_data_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    check("st_beat_seen", ok, 1);
    check("st_rd0", bus_st.app_rd_data, 64'hA5A5_0000_0000_A5A5);
    check("st_end0", bus_st.app_rd_data_end, 0);
    step();
    check("st_rd1", bus_st.app_rd_data, 64'h5A5A_FFFF_FFFF_5A5A);
    check("st_end1", bus_st.app_rd_data_end, 1);
    check("st_valid1", bus_st.app_rd_data_valid, 1);

    // Illegal command: error flag, no beats.
    b0 = beats;
    send_cmd(3'h2, 27'h10, acc);
    repeat (4) step();
    check("perr_bad_cmd", bus.protocol_err, 1);
    check("bad_cmd_no_beats", beats - b0, 0);

    // Reset in the middle of a read's latency wait.
    do_read(27'h40, 1);
    repeat (3) step();
    rst = 1'b1;
    sb.delete();
    b0 = beats;
    step();
    check("perr_after_rst", bus.protocol_err, 0);
    check("valid_after_rst", bus.app_rd_data_valid, 0);
    step();
    rst = 1'b0;
    repeat (20) step();
    check("no_beats_after_rst", beats - b0, 0);
    do_read(27'h10, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
